// File: rtl/pmem_load_ctrl.sv
// Program memory load controller. The 32-word program memory is shared
// between instruction fetch and a byte-serial loader. In RUN the memory
// address follows the fetch counter. A load request holds the core, packs
// incoming bytes MSB-first into 32-bit words and writes them to consecutive
// addresses starting at 0. The core is then released so fetch restarts at 0.
module pmem_load_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_REQ,
    input  logic [ADDR_W:0]   WORD_COUNT,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    input  logic [ADDR_W-1:0] FETCH_ADDR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DATA,
    output logic              MEM_WRITE,
    output logic              CORE_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);

    // Depth 2^ADDR_W needs the extra count bit, so it is built as 1 followed by zeros.
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam int              TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] load_addr;
    logic [1:0]        byte_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [31:0]       word;
    logic              err_q;

    logic req_ok;
    logic accept;
    logic last_byte;
    logic timed_out;
    logic last_word;

    assign req_ok    = (WORD_COUNT != '0) && (WORD_COUNT <= DEPTH);
    assign accept    = (state == S_RECV) && BYTE_VALID;
    assign last_byte = (byte_idx == 2'd3);
    // Abort on the first idle edge after the counter has already reached its last value.
    assign timed_out = (state == S_RECV) && !BYTE_VALID && (to_cnt == TO_LAST);
    // Compare in ADDR_W+1 bits so a full-depth load ends at the top address without wrapping.
    assign last_word = ({1'b0, load_addr} == (count - 1'b1));

    // Outputs are decoded from the state register only; READY never depends on VALID.
    assign BYTE_READY = (state == S_RECV);
    assign MEM_WRITE  = (state == S_WRITE);
    assign CORE_HOLD  = (state != S_RUN);
    assign LOAD_DONE  = (state == S_DONE);
    assign LOAD_ERR   = err_q;
    assign MEM_DATA   = word;

    // Fetch owns the memory address in RUN; the loader owns it otherwise.
    always_comb begin
        MEM_ADDR = load_addr;
        if (state == S_RUN) MEM_ADDR = FETCH_ADDR;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_RUN;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (LOAD_REQ && req_ok) state_nxt = S_RECV;
            S_RECV: begin
                if (accept && last_byte) state_nxt = S_WRITE;
                else if (timed_out)      state_nxt = S_RUN;
            end
            S_WRITE: state_nxt = last_word ? S_DONE : S_RECV;
            S_DONE:  state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Load datapath: count latch, word assembly, byte index, address and idle timer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count     <= '0;
            load_addr <= '0;
            byte_idx  <= '0;
            to_cnt    <= '0;
            word      <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= ((state == S_RUN) && LOAD_REQ && !req_ok) || timed_out;
            case (state)
                S_RUN: begin
                    if (LOAD_REQ && req_ok) begin
                        count     <= WORD_COUNT;
                        load_addr <= '0;
                        byte_idx  <= '0;
                        to_cnt    <= '0;
                    end
                end
                S_RECV: begin
                    if (BYTE_VALID) begin
                        word     <= {word[23:0], BYTE_IN};
                        byte_idx <= byte_idx + 2'd1;
                        to_cnt   <= '0;
                    end else if (timed_out) begin
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!last_word) load_addr <= load_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_load_ctrl.sv
// Bench for pmem_load_ctrl: random words and byte gaps against a simple
// word-list model of what a load must write, plus reset, illegal-request,
// timeout and reset-mid-load scenarios.
module tb_pmem_load_ctrl;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              LOAD_REQ = 1'b0;
    logic [ADDR_W:0]   WORD_COUNT = '0;
    logic [7:0]        BYTE_IN = '0;
    logic              BYTE_VALID = 1'b0;
    logic              BYTE_READY;
    logic [ADDR_W-1:0] FETCH_ADDR = '0;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_DATA;
    logic              MEM_WRITE;
    logic              CORE_HOLD;
    logic              LOAD_DONE;
    logic              LOAD_ERR;

    pmem_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .LOAD_REQ(LOAD_REQ), .WORD_COUNT(WORD_COUNT),
        .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
        .FETCH_ADDR(FETCH_ADDR), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .MEM_WRITE(MEM_WRITE), .CORE_HOLD(CORE_HOLD), .LOAD_DONE(LOAD_DONE),
        .LOAD_ERR(LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed activity, gathered on the falling edge.
    int cyc = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int done_cnt, err_cnt, both_cnt, hold_cnt, nr_cnt;
    int run_addr_bad, run_wr_bad, last_acc, err_at;
    logic fetch_rand = 1'b0;

    logic [31:0] exp_w [DEPTH];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (MEM_WRITE) begin
            wr_addr.push_back(MEM_ADDR);
            wr_data.push_back(MEM_DATA);
        end
        if (LOAD_DONE) done_cnt++;
        if (LOAD_ERR) begin err_cnt++; err_at = cyc; end
        if (LOAD_DONE && LOAD_ERR) both_cnt++;
        if (CORE_HOLD) hold_cnt++;
        if (CORE_HOLD && !BYTE_READY) nr_cnt++;
        if (BYTE_VALID && BYTE_READY) last_acc = cyc + 1;
        if (!CORE_HOLD && MEM_ADDR !== FETCH_ADDR) run_addr_bad++;
        if (!CORE_HOLD && MEM_WRITE) run_wr_bad++;
    end

    // Fetch counter stand-in: wanders randomly while enabled.
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (fetch_rand) FETCH_ADDR = ADDR_W'($urandom);
        end
    end

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete();
        done_cnt = 0; err_cnt = 0; both_cnt = 0; hold_cnt = 0; nr_cnt = 0;
        run_addr_bad = 0; run_wr_bad = 0; last_acc = 0; err_at = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        BYTE_VALID = 1'b0;
        tick(gap);
        BYTE_VALID = 1'b1;
        BYTE_IN = b;
        t = 0;
        @(negedge CLK);
        while (!BYTE_READY && t < 20) begin @(negedge CLK); t++; end
        n_cmp++;
        if (t >= 20) begin n_bad++; $display("FAIL byte_accept_wait: ready=%0b want 1", BYTE_READY); end
        @(posedge CLK); #1;
        BYTE_VALID = 1'b0;
    endtask

    task automatic issue_req(input logic [ADDR_W:0] n);
        LOAD_REQ = 1'b1;
        WORD_COUNT = n;
        tick(1);
        LOAD_REQ = 1'b0;
    endtask

    task automatic wait_release();
        int t;
        t = 0;
        @(negedge CLK);
        while (CORE_HOLD && t < 400) begin @(negedge CLK); t++; end
        n_cmp++;
        if (t >= 400) begin n_bad++; $display("FAIL release_wait: hold=%0b want 0", CORE_HOLD); end
        tick(2);
    endtask

    task automatic test_reset();
        fetch_rand = 1'b0;
        FETCH_ADDR = 5'd7;
        RST = 1'b1;
        tick(2);
        @(negedge CLK);
        n_cmp++; if (CORE_HOLD !== 1'b0) begin n_bad++; $display("FAIL rst_hold: got %0b want 0", CORE_HOLD); end
        n_cmp++; if (MEM_DATA !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", MEM_DATA); end
        RST = 1'b0;
        BYTE_VALID = 1'b1;
        BYTE_IN = 8'h55;
        tick(1);
        clear_mon();
        tick(4);
        @(negedge CLK);
        n_cmp++; if (MEM_ADDR !== 5'd7) begin n_bad++; $display("FAIL run_addr: got %0d want 7", MEM_ADDR); end
        n_cmp++; if (MEM_WRITE !== 1'b0) begin n_bad++; $display("FAIL run_write: got %0b want 0", MEM_WRITE); end
        n_cmp++; if (BYTE_READY !== 1'b0) begin n_bad++; $display("FAIL run_ready: got %0b want 0", BYTE_READY); end
        n_cmp++; if (hold_cnt + done_cnt + err_cnt !== 0) begin n_bad++; $display("FAIL run_quiet: hold/done/err=%0d/%0d/%0d want 0", hold_cnt, done_cnt, err_cnt); end
        BYTE_VALID = 1'b0;
        tick(1);
        fetch_rand = 1'b1;
    endtask

    // Full load of n words with random gaps in [gmin,gmax]; checks against exp_w.
    task automatic run_load(input string tag, input int n, input int gmin, input int gmax);
        clear_mon();
        issue_req(n[ADDR_W:0]);
        for (int w = 0; w < n; w++)
            for (int k = 3; k >= 0; k--)
                send_byte(exp_w[w][k*8 +: 8], $urandom_range(gmax, gmin));
        wait_release();
        n_cmp++;
        if (wr_addr.size() !== n) begin n_bad++; $display("FAIL %s_nwrites: got %0d want %0d", tag, wr_addr.size(), n); end
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL %s_write%0d: got %0d:%h want %0d:%h", tag, i, wr_addr[i], wr_data[i], i, exp_w[i]);
            end
        end
        n_cmp++; if (done_cnt !== 1 || err_cnt !== 0) begin n_bad++; $display("FAIL %s_pulses: done=%0d err=%0d want 1/0", tag, done_cnt, err_cnt); end
        n_cmp++; if (nr_cnt !== n + 1) begin n_bad++; $display("FAIL %s_ready_gaps: got %0d want %0d", tag, nr_cnt, n + 1); end
        if (gmax == 0) begin
            n_cmp++; if (hold_cnt !== 5 * n + 1) begin n_bad++; $display("FAIL %s_hold_cycles: got %0d want %0d", tag, hold_cnt, 5 * n + 1); end
        end
        n_cmp++;
        if (both_cnt !== 0 || run_addr_bad !== 0 || run_wr_bad !== 0) begin
            n_bad++;
            $display("FAIL %s_run_side: both=%0d addr_bad=%0d wr_bad=%0d want 0", tag, both_cnt, run_addr_bad, run_wr_bad);
        end
    endtask

    task automatic test_two_word();
        exp_w[0] = 32'hDEADBEEF;
        exp_w[1] = 32'h12345678;
        run_load("two_word", 2, 0, 0);
    endtask

    task automatic test_throttled();
        exp_w[0] = 32'hDEADBEEF;
        exp_w[1] = 32'h12345678;
        run_load("throttled", 2, 1, 1);
    endtask

    task automatic test_illegal();
        logic [ADDR_W:0] bad [3];
        bad[0] = 6'd0; bad[1] = 6'd33; bad[2] = 6'd63;
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            issue_req(bad[i]);
            @(negedge CLK);
            n_cmp++; if (LOAD_ERR !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_err_now: got %0b want 1", bad[i], LOAD_ERR); end
            tick(4);
            n_cmp++;
            if (err_cnt !== 1 || hold_cnt !== 0 || wr_addr.size() !== 0 || done_cnt !== 0) begin
                n_bad++;
                $display("FAIL illegal%0d: err=%0d hold=%0d wr=%0d done=%0d want 1/0/0/0", bad[i], err_cnt, hold_cnt, wr_addr.size(), done_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        int t;
        clear_mon();
        exp_w[0] = $urandom;
        exp_w[1] = $urandom;
        issue_req(6'd2);
        for (int b = 0; b < 5; b++)
            send_byte(exp_w[b / 4][(3 - b % 4) * 8 +: 8], 0);
        t = 0;
        while (err_cnt == 0 && t < 40) begin tick(1); t++; end
        tick(3);
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt); end
        n_cmp++; if (err_at - last_acc !== TIMEOUT) begin n_bad++; $display("FAIL timeout_delay: got %0d want %0d", err_at - last_acc, TIMEOUT); end
        n_cmp++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== exp_w[0]) begin
            n_bad++; $display("FAIL timeout_writes: got %0d writes want 1 at addr0=%h", wr_addr.size(), exp_w[0]);
        end
        @(negedge CLK);
        n_cmp++; if (CORE_HOLD !== 1'b0 || done_cnt !== 0) begin n_bad++; $display("FAIL timeout_run: hold=%0b done=%0d want 0/0", CORE_HOLD, done_cnt); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = (r == 0) ? 1 : $urandom_range(DEPTH, 2);
            for (int i = 0; i < n; i++) exp_w[i] = $urandom;
            run_load("random", n, 0, 4);
        end
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) exp_w[i] = $urandom;
        run_load("full", DEPTH, 0, 0);
    endtask

    task automatic test_reset_mid_load();
        clear_mon();
        for (int i = 0; i < DEPTH; i++) exp_w[i] = $urandom;
        issue_req(6'd32);
        for (int b = 0; b < 12; b++)
            send_byte(exp_w[b / 4][(3 - b % 4) * 8 +: 8], 0);
        tick(1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        BYTE_VALID = 1'b1;
        BYTE_IN = 8'hA5;
        @(negedge CLK);
        n_cmp++; if (CORE_HOLD !== 1'b0 || BYTE_READY !== 1'b0) begin n_bad++; $display("FAIL midrst_state: hold=%0b ready=%0b want 0/0", CORE_HOLD, BYTE_READY); end
        tick(12);
        BYTE_VALID = 1'b0;
        n_cmp++; if (wr_addr.size() !== 3) begin n_bad++; $display("FAIL midrst_writes: got %0d want 3", wr_addr.size()); end
        n_cmp++; if (done_cnt !== 0 || run_wr_bad !== 0) begin n_bad++; $display("FAIL midrst_quiet: done=%0d wr_bad=%0d want 0/0", done_cnt, run_wr_bad); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_throttled();
        test_illegal();
        test_timeout();
        test_random();
        test_full_depth();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pmem_load_ctrl.md
Name: pmem_load_ctrl

Overview:
Controller that shares the 32x32-bit program memory between instruction fetch and a byte-serial program loader, for example one fed by a UART receiver.
- In RUN, the memory address follows the fetch counter and writes are disabled.
- On a load request, the block holds the core, assembles incoming bytes into 32-bit words (MSB first) and writes them to consecutive addresses from 0.
- It then releases the core so fetch restarts at address 0.
- Sits between the fetch counter, the program memory and the loader front end.

Parameters:
ADDR_W, 5, program memory address width; depth = 2^ADDR_W words.
TIMEOUT, 50000, max idle cycles between bytes in RECV before the load aborts; minimum 2.

Ports:
CLK  input  1  clock; all state changes on posedge.
RST  input  1  reset: RST, synchronous, active-high; clock CLK.
LOAD_REQ  input  1  level/pulse; sampled only in RUN; starts a load.
WORD_COUNT  input  ADDR_W+1  number of words to load, sampled with LOAD_REQ; legal 1..2^ADDR_W.
BYTE_IN  input  8  loader byte.
BYTE_VALID  input  1  byte valid from loader.
BYTE_READY  output  1  block accepts byte when VALID&READY at posedge.
FETCH_ADDR  input  ADDR_W  address from fetch counter.
MEM_ADDR  output  ADDR_W  address to program memory.
MEM_DATA  output  32  write data to program memory.
MEM_WRITE  output  1  write strobe to program memory.
CORE_HOLD  output  1  ORed into fetch counter reset and core reset; 1 = core held.
LOAD_DONE  output  1  one-cycle pulse on successful completion.
LOAD_ERR  output  1  one-cycle pulse on rejected request or timeout abort.

Behaviour:
- States: RUN, RECV, WRITE, DONE. Encoding is free.
- All outputs and internal counters are registered/decoded from state; there is no combinational path from BYTE_VALID to BYTE_READY.
- Reset values (RST=1 at posedge, regardless of state):
  - state=RUN.
  - BYTE_READY=0, MEM_WRITE=0, CORE_HOLD=0, LOAD_DONE=0, LOAD_ERR=0.
  - MEM_DATA=0, word register=0, byte index=0, load address=0, timeout counter=0.
  - Reset mid-load aborts immediately; no further writes.
- RUN:
  - MEM_ADDR=FETCH_ADDR (combinational mux); MEM_WRITE=0; CORE_HOLD=0; BYTE_READY=0.
  - LOAD_REQ=1 with WORD_COUNT in 1..2^ADDR_W: latch count; clear load address, byte index and timeout; next state RECV.
  - LOAD_REQ=1 with WORD_COUNT=0 or >2^ADDR_W: LOAD_ERR=1 next cycle; stay RUN.
  - Bytes presented in RUN are not accepted.
- RECV:
  - CORE_HOLD=1; BYTE_READY=1; MEM_ADDR=load address; MEM_WRITE=0.
  - On accept: word <= {word[23:0], BYTE_IN}; byte index +1; timeout counter cleared.
  - Accept of the 4th byte (index 3): index wraps to 0; next state WRITE.
  - No accept: timeout counter +1. When it reaches TIMEOUT-1 without an accept, go to RUN with LOAD_ERR=1 for one cycle.
  - On timeout abort, words already written remain in memory; the partial word is discarded.
  - LOAD_REQ is ignored.
- WRITE (exactly 1 cycle):
  - BYTE_READY=0; MEM_WRITE=1; MEM_ADDR=load address; MEM_DATA=assembled word; CORE_HOLD=1.
  - If load address == count-1: next state DONE. Otherwise load address +1 and go to RECV.
- DONE (1 cycle):
  - CORE_HOLD=1; MEM_WRITE=0; LOAD_DONE=1 (asserted during the DONE cycle); next state RUN.
  - CORE_HOLD falls on entry to RUN, so the fetch counter resumes from 0.
- Throughput: at most 1 byte per cycle in RECV; each word costs 4 accept cycles + 1 WRITE cycle.
- Address arithmetic: load address is ADDR_W bits. The comparison against count-1 uses ADDR_W+1 bits, so count=2^ADDR_W ends at address 2^ADDR_W-1 with no wrap.
- LOAD_DONE and LOAD_ERR never assert in the same cycle.

Test Plan:
1. Reset, then RUN: RST high 2 cycles, then FETCH_ADDR=7 -> MEM_ADDR=7, MEM_WRITE=0, CORE_HOLD=0, BYTE_READY=0, no pulses.
2. Two-word load: LOAD_REQ with WORD_COUNT=2; bytes DE AD BE EF 12 34 56 78 back-to-back.
   - Writes: addr0=0xDEADBEEF, then addr1=0x12345678, one MEM_WRITE each.
   - LOAD_DONE pulses once; CORE_HOLD high from the cycle after LOAD_REQ through DONE, then low.
   - Total 11 cycles from LOAD_REQ to RUN.
3. Throttled source: same load with BYTE_VALID toggling every other cycle -> identical writes; BYTE_READY drops only in WRITE/DONE.
4. Illegal request: WORD_COUNT=0 and WORD_COUNT=33 (ADDR_W=5) -> LOAD_ERR one-cycle pulse each; stays RUN; CORE_HOLD stays 0; no writes.
5. Timeout: TIMEOUT=8, WORD_COUNT=2; send 5 bytes then stop.
   - addr0 written; LOAD_ERR pulses 8 cycles after the last accept; returns to RUN.
   - Nothing written to addr1.
6. Full depth and reset mid-load:
   - WORD_COUNT=32 -> addresses 0..31 written, last write to 31, LOAD_DONE.
   - Repeat, asserting RST after word 3 -> immediate RUN, CORE_HOLD=0, no further writes.
